// File: rtl/jt5205_enc_if.sv
// Sample-in / ADPCM-code-out bundle for the jt5205_enc encoder.
interface jt5205_enc_if;
  logic signed [11:0] pcm_in;
  logic               pcm_valid;
  logic               busy;
  logic        [3:0]  code;
  logic               code_valid;
  logic signed [11:0] pred;
  logic        [5:0]  step_idx;

  modport master (
    output pcm_in, pcm_valid,
    input  busy, code, code_valid, pred, step_idx
  );

  modport slave (
    input  pcm_in, pcm_valid,
    output busy, code, code_valid, pred, step_idx
  );
endinterface

// File: rtl/jt5205_enc.sv
// MSM5205-compatible ADPCM encoder: 3-step successive approximation of |pcm - pred|,
// then the same reconstruction and step adaptation as the JT5205 decoder.
module jt5205_enc (
  input  logic         clk,
  input  logic         rst,
  input  logic         cen,
  jt5205_enc_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StSar2, StSar1, StSar0, StUpd} state_e;

  state_e             state_q, state_d;
  logic        [11:0] rem_q, rem_d;
  logic        [10:0] dn_q, dn_d;
  logic        [11:0] qn_q, qn_d;
  logic               sgn_q, sgn_d;
  logic        [2:0]  bits_q, bits_d;
  logic signed [11:0] pred_q, pred_d;
  logic        [5:0]  step_q, step_d;
  logic        [3:0]  code_q, code_d;
  logic               code_valid_q, code_valid_d;

  logic signed [12:0] diff;
  logic        [12:0] mag;
  logic        [10:0] step_size;
  logic               sar_hit;
  logic signed [13:0] ext_pred, ext_qn, unlim;
  logic        [6:0]  step_sum;

  always_comb begin
    unique case (step_q)
      6'd0:  step_size = 11'd16;   6'd1:  step_size = 11'd17;   6'd2:  step_size = 11'd19;
      6'd3:  step_size = 11'd21;   6'd4:  step_size = 11'd23;   6'd5:  step_size = 11'd25;
      6'd6:  step_size = 11'd28;   6'd7:  step_size = 11'd31;   6'd8:  step_size = 11'd34;
      6'd9:  step_size = 11'd37;   6'd10: step_size = 11'd41;   6'd11: step_size = 11'd45;
      6'd12: step_size = 11'd50;   6'd13: step_size = 11'd55;   6'd14: step_size = 11'd60;
      6'd15: step_size = 11'd66;   6'd16: step_size = 11'd73;   6'd17: step_size = 11'd80;
      6'd18: step_size = 11'd88;   6'd19: step_size = 11'd97;   6'd20: step_size = 11'd107;
      6'd21: step_size = 11'd118;  6'd22: step_size = 11'd130;  6'd23: step_size = 11'd143;
      6'd24: step_size = 11'd157;  6'd25: step_size = 11'd173;  6'd26: step_size = 11'd190;
      6'd27: step_size = 11'd209;  6'd28: step_size = 11'd230;  6'd29: step_size = 11'd253;
      6'd30: step_size = 11'd279;  6'd31: step_size = 11'd307;  6'd32: step_size = 11'd337;
      6'd33: step_size = 11'd371;  6'd34: step_size = 11'd408;  6'd35: step_size = 11'd449;
      6'd36: step_size = 11'd494;  6'd37: step_size = 11'd544;  6'd38: step_size = 11'd598;
      6'd39: step_size = 11'd658;  6'd40: step_size = 11'd724;  6'd41: step_size = 11'd796;
      6'd42: step_size = 11'd876;  6'd43: step_size = 11'd963;  6'd44: step_size = 11'd1060;
      6'd45: step_size = 11'd1166; 6'd46: step_size = 11'd1282; 6'd47: step_size = 11'd1411;
      default: step_size = 11'd1552;
    endcase
  end

  always_comb begin
    diff     = {bus.pcm_in[11], bus.pcm_in} - {pred_q[11], pred_q};
    mag      = diff[12] ? 13'(-diff) : 13'(diff);
    sar_hit  = (rem_q >= {1'b0, dn_q});
    ext_pred = {{2{pred_q[11]}}, pred_q};
    ext_qn   = {2'b00, qn_q};
    unlim    = sgn_q ? (ext_pred - ext_qn) : (ext_pred + ext_qn);
    // b2 set: step grows by 2*(b1b0+1), i.e. 2,4,6,8
    step_sum = {1'b0, step_q} + {4'b0, bits_q[1:0], 1'b0} + 7'd2;
  end

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    dn_d         = dn_q;
    qn_d         = qn_q;
    sgn_d        = sgn_q;
    bits_d       = bits_q;
    pred_d       = pred_q;
    step_d       = step_q;
    code_d       = code_q;
    code_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.pcm_valid) begin
          sgn_d   = diff[12];
          rem_d   = mag[11:0];
          dn_d    = step_size;
          qn_d    = {4'b0, step_size[10:3]};
          bits_d  = 3'b000;
          state_d = StSar2;
        end
      end
      StSar2, StSar1, StSar0: begin
        // Code bits shift in MSB first, so after SAR0 bits_q = {b2,b1,b0}
        if (sar_hit) begin
          rem_d = rem_q - {1'b0, dn_q};
          qn_d  = qn_q + {1'b0, dn_q};
        end
        bits_d  = {bits_q[1:0], sar_hit};
        dn_d    = dn_q >> 1;
        state_d = (state_q == StSar2) ? StSar1 :
                  (state_q == StSar1) ? StSar0 : StUpd;
      end
      StUpd: begin
        if (unlim > 14'sd2047) begin
          pred_d = 12'h7ff;
        end else if (unlim < -14'sd2048) begin
          pred_d = 12'h800;
        end else begin
          pred_d = unlim[11:0];
        end
        if (bits_q[2]) begin
          step_d = (step_sum > 7'd48) ? 6'd48 : step_sum[5:0];
        end else begin
          step_d = (step_q == 6'd0) ? 6'd0 : step_q - 6'd1;
        end
        code_d       = {sgn_q, bits_q};
        code_valid_d = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      rem_q        <= '0;
      dn_q         <= '0;
      qn_q         <= '0;
      sgn_q        <= 1'b0;
      bits_q       <= '0;
      pred_q       <= '0;
      step_q       <= '0;
      code_q       <= '0;
      code_valid_q <= 1'b0;
    end else if (cen) begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      dn_q         <= dn_d;
      qn_q         <= qn_d;
      sgn_q        <= sgn_d;
      bits_q       <= bits_d;
      pred_q       <= pred_d;
      step_q       <= step_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
    end
  end

  assign bus.busy       = (state_q != StIdle);
  assign bus.code       = code_q;
  assign bus.code_valid = code_valid_q;
  assign bus.pred       = pred_q;
  assign bus.step_idx   = step_q;

endmodule
